i2c_slave_target: RTL and testbench
===================================

# i2c_slave_target

Open-drain I2C slave (target) endpoint that sits on the far side of the bus from `i2c_master`, consuming the START/address/data/STOP sequences it produces. It decodes a 7-bit address and ACKs matching transactions. On writes it delivers each received byte to fabric logic. On reads it fetches bytes from fabric logic and serialises them onto SDA. It is the bench-and-silicon counterpart used to close the loop on the master.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h50, 7-bit address this target responds to.
- `SYNC_STAGES`, 2, synchroniser depth on SCL/SDA inputs (min 2).

Ports:
- `clk`  input  1  system clock; one clock domain.
- `reset`  input  1  asynchronous, active-high reset.
- `scl`  input  1  I2C clock line; sampled only, never driven (no clock stretching).
- `sda`  inout  1  I2C data line; open-drain: driven 0 or released to `z`, never driven 1.
- `rx_data`  output  8  last byte written by master.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` updated.
- `tx_data`  input  8  byte to return on the next read byte slot.
- `tx_req`  output  1  one-cycle pulse: `tx_data` captured; fabric may change it afterwards.
- `busy`  output  1  high from address match until STOP/START/mismatch release.

## Operation
- Line monitor: SCL/SDA pass through `SYNC_STAGES` flops, then one more register for edge detect. Both lines share the same delay, so their ordering is preserved.
- START: synced SDA falls while synced SCL high. STOP: synced SDA rises while SCL high.
- START from any state: go to ADDR, bit count 7, SDA released. This covers repeated START.
- STOP from any state: go to IDLE, SDA released, `busy`=0.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first on SCL rising edges.
    - At the 8th falling edge with `addr[7:1]==SLAVE_ADDR`: go to ADDR_ACK and drive SDA=0.
    - Otherwise go to WAIT_STOP with SDA released.
  - ADDR_ACK: at the next SCL falling edge, release SDA.
    - R/W=0: go to WR_BYTE.
    - R/W=1: load `tx_data` into the shift register, pulse `tx_req`, drive the MSB, go to RD_BYTE.
  - WR_BYTE: samples 8 bits on rising edges. On the 8th rising edge, `rx_data` is updated and `rx_valid` pulses. The 8th falling edge moves to WR_ACK with SDA=0.
  - WR_ACK: the next falling edge releases SDA and returns to WR_BYTE.
  - RD_BYTE: after each falling edge, drive the next bit (oe = ~bit). The 8th falling edge releases SDA and moves to RD_ACK.
  - RD_ACK: sample master ACK on the rising edge. At the falling edge:
    - ACK (0): reload `tx_data`, pulse `tx_req`, go to RD_BYTE.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START/STOP leave it.
- Byte counting: `bit_cnt` is 3 bits and counts down 7→0; it wraps to 7 on every ACK slot.
- The fabric never back-pressures. A write byte overwrites `rx_data` even if the previous byte was unconsumed.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `tx_req`=0, `busy`=0, SDA released, state IDLE. Reset asserted mid-transaction releases SDA asynchronously. The target ignores the bus until the next START.
- Detection latency: `SYNC_STAGES`+1 `clk` cycles after a line change.
- SDA update latency: SDA changes ≤ `SYNC_STAGES`+2 cycles after the physical SCL fall.
- Hold and setup requirement: this latency guarantees hold after the fall and setup before the next rise. It requires ≥ 8 `clk` per SCL half-period; the master default of 100 MHz/5 MHz gives 10.
- `rx_valid`: pulses 1 cycle after the detected 8th rising edge of a data byte.
- `tx_req`: pulses in the same cycle the shift register loads.
- Simultaneous events: a START or STOP detected in the same cycle as an SCL edge takes priority. An SDA transition while SCL is high is never data.
- `busy`: rises with the ADDR_ACK entry and falls on STOP, on a new START, or on entering WAIT_STOP.

## Structure
- Shared package `i2c_pkg`: state encoding localparams, the 7-bit address width, and ACK/NACK constants (ACK=0), shared with `i2c_master`.
- One sub-module, `i2c_line_monitor`: synchronisers plus `scl_rise`, `scl_fall`, `start_det`, `stop_det` outputs.
- Top level: the FSM, shift register, and open-drain tristate.

## Test plan
- Write, addr 0x50, data 0xA5, 0x3C, then STOP:
  - ACK on the address and both bytes.
  - `rx_valid` pulses twice with `rx_data`=0xA5 then 0x3C.
  - `busy` falls at STOP.
- Addr 0x51 write:
  - SDA never driven low.
  - No `rx_valid`.
  - `busy` stays 0.
  - A following STOP then a START with 0x50 is ACKed.
- Read, addr 0x50, `tx_data`=0xC3, master ACK, `tx_data`=0x5A, master NACK, STOP:
  - Master captures 0xC3, 0x5A.
  - `tx_req` pulses twice.
  - SDA released after the NACK.
- Write 0x11, then repeated START with read:
  - `rx_data`=0x11.
  - The read returns `tx_data` with no intervening STOP.
- Reset asserted during bit 4 of a read byte:
  - SDA is `z` within the same cycle.
  - All outputs at reset values.
  - The next full transaction completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared I2C definitions used by the target endpoint and its master counterpart.
package i2c_pkg;

  localparam int ADDR_W = 7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WR_BYTE   = 3'd3;
  localparam logic [2:0] ST_WR_ACK    = 3'd4;
  localparam logic [2:0] ST_RD_BYTE   = 3'd5;
  localparam logic [2:0] ST_RD_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // True when the upper seven bits of a received address byte select this target.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [ADDR_W-1:0] own_addr);
    return addr_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_line_monitor.sv
`timescale 1ns/1ps
// Synchronises SCL/SDA into the clk domain and flags edges and bus conditions.
// Both lines go through identical delay so their relative ordering survives.
module i2c_line_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;
  logic                   sda_s;

  // Next-state of the synchroniser chains and the edge-detect registers.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Idle bus is high on both lines, so reset everything to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign sda_sync  = sda_s;
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_target.sv
`timescale 1ns/1ps
// I2C target endpoint: address decode, write delivery to fabric, read serialisation.
// SDA is open-drain: only ever pulled low or released.
module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic       sda_sync;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done_q, byte_done_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  i2c_line_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_monitor (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .sda_sync (sda_sync),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // Protocol FSM: bus conditions pre-empt any SCL edge seen in the same cycle.
  // Byte framing counts rising edges, so the SCL fall that follows START is ignored.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd7;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_sync};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (addr_match(shift_q, SLAVE_ADDR)) begin
              state_d  = ST_ADDR_ACK;
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              shift_d   = tx_data;
              tx_req_d  = 1'b1;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd7;
              state_d   = ST_RD_BYTE;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = ST_WR_BYTE;
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_sync};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              byte_done_d = 1'b1;
              rx_data_d   = {shift_q[6:0], sda_sync};
              rx_valid_d  = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = ST_WR_ACK;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WR_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_sync;
          end else if (scl_fall) begin
            if (ack_q == ACK) begin
              shift_d   = tx_data;
              tx_req_d  = 1'b1;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd7;
              state_d   = ST_RD_BYTE;
            end else begin
              sda_oe_d  = 1'b0;
              busy_d    = 1'b0;
              state_d   = ST_WAIT_STOP;
            end
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers; the async reset releases SDA immediately, mid-transaction included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      ack_q       <= NACK;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
`timescale 1ns/1ps
// Self-checking bench for i2c_slave_target: a bit-banged bus master, a fabric model
// feeding tx_data, and scoreboards for written and read bytes.
module tb_i2c_slave_target;

  localparam int HALF = 10;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wr_vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_low;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  wire        sda;

  int n_compared   = 0;
  int n_mismatched = 0;
  int tx_req_cnt   = 0;
  logic dut_low_seen = 1'b0;
  logic rx_valid_prev = 1'b0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] fabric_q[$];

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  // Free-running 100 MHz system clock.
  always #5 clk = ~clk;

  i2c_slave_target #(
    .SLAVE_ADDR (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard for writes, fabric model for reads, and a watch for the target pulling SDA.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL rx_unexpected: got rx_valid with 0x%0h, expected none", rx_data);
        end else begin
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
        end
        if (rx_valid_prev) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL rx_valid_width: got 2+ cycles, expected 1");
        end
      end
      if (tx_req) begin
        tx_req_cnt++;
        if (fabric_q.size() > 0) void'(fabric_q.pop_front());
      end
      if (sda === 1'b0 && !sda_low) dut_low_seen = 1'b1;
    end
    tx_data = (fabric_q.size() > 0) ? fabric_q[0] : 8'h00;
    rx_valid_prev = rx_valid;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clks(HALF);
    sda_low = 1'b1;
    wait_clks(HALF);
    scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clks(HALF/2);
    sda_low = 1'b0;
    wait_clks(HALF/2);
    scl = 1'b1;
    wait_clks(HALF);
    sda_low = 1'b1;
    wait_clks(HALF);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(HALF/2);
    sda_low = 1'b1;
    wait_clks(HALF/2);
    scl = 1'b1;
    wait_clks(HALF);
    sda_low = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic write_bit(input logic b);
    wait_clks(HALF/2);
    sda_low = ~b;
    wait_clks(HALF/2);
    scl = 1'b1;
    wait_clks(HALF);
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clks(2);
    sda_low = 1'b0;
    wait_clks(HALF-2);
    scl = 1'b1;
    wait_clks(HALF/2);
    b = sda;
    wait_clks(HALF/2);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    acked = (a == 1'b0);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bit_v);
      b[i] = bit_v;
    end
    write_bit(send_ack ? 1'b0 : 1'b1);
  endtask

  // One complete write transaction: START, address, two data bytes, STOP.
  task automatic applyStimulus(input wr_vec_t v);
    logic a;
    dut_low_seen = 1'b0;
    i2c_start();
    write_byte({v.addr, 1'b0}, a);
    checkOutput("addr_ack", {31'd0, a}, {31'd0, v.exp_ack});
    checkOutput("busy_after_addr", {31'd0, busy}, {31'd0, v.exp_ack});
    if (v.exp_ack) exp_rx_q.push_back(v.d0);
    write_byte(v.d0, a);
    checkOutput("d0_ack", {31'd0, a}, {31'd0, v.exp_ack});
    if (v.exp_ack) exp_rx_q.push_back(v.d1);
    write_byte(v.d1, a);
    checkOutput("d1_ack", {31'd0, a}, {31'd0, v.exp_ack});
    i2c_stop();
    wait_clks(5);
    checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
    checkOutput("rx_pending", exp_rx_q.size(), 32'd0);
    if (!v.exp_ack) checkOutput("no_sda_drive", {31'd0, dut_low_seen}, 32'd0);
  endtask

  initial begin
    wr_vec_t    vecs[4];
    logic       a;
    logic       b;
    logic [7:0] rd;
    int         tx_before;

    vecs[0] = '{addr: 7'h50, d0: 8'hA5, d1: 8'h3C, exp_ack: 1'b1};
    vecs[1] = '{addr: 7'h51, d0: 8'h12, d1: 8'h34, exp_ack: 1'b0};
    vecs[2] = '{addr: 7'h50, d0: 8'h00, d1: 8'hFF, exp_ack: 1'b1};
    vecs[3] = '{addr: 7'h28, d0: 8'h50, d1: 8'hA0, exp_ack: 1'b0};

    reset   = 1'b1;
    scl     = 1'b1;
    sda_low = 1'b0;
    wait_clks(4);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_tx_req", {31'd0, tx_req}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_sda", {31'd0, sda}, 32'd1);
    reset = 1'b0;
    wait_clks(HALF);

    $display("[TB] write vectors");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
    checkOutput("rx_data_last", {24'd0, rx_data}, 32'hFF);

    $display("[TB] read with ACK then NACK");
    fabric_q.push_back(8'hC3); exp_rd_q.push_back(8'hC3);
    fabric_q.push_back(8'h5A); exp_rd_q.push_back(8'h5A);
    wait_clks(2);
    tx_before = tx_req_cnt;
    i2c_start();
    write_byte({7'h50, 1'b1}, a);
    checkOutput("rd_addr_ack", {31'd0, a}, 32'd1);
    read_byte(1'b1, rd);
    checkOutput("rd_byte0", {24'd0, rd}, {24'd0, exp_rd_q.pop_front()});
    read_byte(1'b0, rd);
    checkOutput("rd_byte1", {24'd0, rd}, {24'd0, exp_rd_q.pop_front()});
    wait_clks(HALF/2);
    checkOutput("sda_after_nack", {31'd0, sda}, 32'd1);
    checkOutput("busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    checkOutput("tx_req_count", tx_req_cnt - tx_before, 32'd2);

    $display("[TB] write then repeated START read");
    fabric_q.push_back(8'h96); exp_rd_q.push_back(8'h96);
    exp_rx_q.push_back(8'h11);
    wait_clks(2);
    i2c_start();
    write_byte({7'h50, 1'b0}, a);
    checkOutput("rs_waddr_ack", {31'd0, a}, 32'd1);
    write_byte(8'h11, a);
    checkOutput("rs_data_ack", {31'd0, a}, 32'd1);
    i2c_rstart();
    write_byte({7'h50, 1'b1}, a);
    checkOutput("rs_raddr_ack", {31'd0, a}, 32'd1);
    read_byte(1'b0, rd);
    checkOutput("rs_rd_byte", {24'd0, rd}, {24'd0, exp_rd_q.pop_front()});
    i2c_stop();
    checkOutput("rs_rx_data", {24'd0, rx_data}, 32'h11);

    $display("[TB] reset during read bit 4");
    fabric_q.push_back(8'hC3);
    wait_clks(2);
    i2c_start();
    write_byte({7'h50, 1'b1}, a);
    checkOutput("rst_addr_ack", {31'd0, a}, 32'd1);
    for (int i = 0; i < 3; i++) read_bit(b);
    wait_clks(HALF/2);
    checkOutput("bit4_driven_low", {31'd0, sda}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rst_sda_released", {31'd0, sda}, 32'd1);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_tx_req", {31'd0, tx_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(HALF/2);
    scl = 1'b1;
    wait_clks(HALF);
    applyStimulus('{addr: 7'h50, d0: 8'h77, d1: 8'h88, exp_ack: 1'b1});
    checkOutput("post_rst_rx_data", {24'd0, rx_data}, 32'h88);

    wait_clks(HALF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
